// File: rtl/angle_reducer_if.sv
// Handshake bundle: float angle in (valid/ready), scaled residual + quadrant out (valid/ready).
interface angle_reducer_if #(parameter int WIDTH = 32);
  logic             valid_in;
  logic [31:0]      angle_in;
  logic             ready;
  logic [WIDTH-1:0] angle_out;
  logic [1:0]       quadrant;
  logic             err;
  logic             valid_out;
  logic             ready_out;

  modport master (output valid_in, angle_in, ready_out,
                  input  ready, angle_out, quadrant, err, valid_out);
  modport slave  (input  valid_in, angle_in, ready_out,
                  output ready, angle_out, quadrant, err, valid_out);
endinterface

// File: rtl/angle_reducer.sv
// Float degrees -> quadrant + residual scaled so 45 deg = 2^(WIDTH-2); N_mod+WIDTH+3 cycles, specials 2.
// Result held until ready_out; ready only in IDLE. ANGLE_REDUCER_ROUND_EN selects round-to-nearest.
module angle_reducer #(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 16
) (
  input logic            clk,
  input logic            rst,
  angle_reducer_if.slave bus
);
`ifdef ANGLE_REDUCER_ROUND_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif
  localparam int FB = FRAC_BITS + G;
  localparam int RW = FB + 10;
  localparam int PW = FRAC_BITS + 8;
  localparam int DI = 1 << FRAC_BITS;
  localparam logic [RW-1:0] QM   = RW'(360 << FB);
  localparam logic [RW:0]   QF   = (RW+1)'(360 * DI);
  localparam logic [RW:0]   T45  = (RW+1)'(45 * DI);
  localparam logic [RW:0]   T135 = (RW+1)'(135 * DI);
  localparam logic [RW:0]   T225 = (RW+1)'(225 * DI);
  localparam logic [RW:0]   T315 = (RW+1)'(315 * DI);
  localparam logic [RW:0]   O90  = (RW+1)'(90 * DI);
  localparam logic [RW:0]   O180 = (RW+1)'(180 * DI);
  localparam logic [RW:0]   O270 = (RW+1)'(270 * DI);
  localparam logic [PW:0]   DV   = (PW+1)'(45 * DI);
`ifdef ANGLE_REDUCER_ROUND_EN
  localparam logic [63:0]   HALF = 64'((45 * DI) / 2);
`else
  localparam logic [63:0]   HALF = 64'd0;
`endif

  typedef enum logic [2:0] {IDLE, CLASSIFY, MOD, FOLD, DIV, DONE} state_t;
  state_t state_q;

  logic [31:0]      ang_q;
  logic [23:0]      m_q;
  logic [4:0]       nb_q;
  logic [7:0]       nz_q;
  logic [RW-1:0]    r_q;
  logic [PW-1:0]    p_q;
  logic [WIDTH-1:0] s_q, quo_q;
  logic [5:0]       cnt_q;
  logic [1:0]       quad_q;
  logic             neg_q, spec_err_q;
  logic             ready_q, err_q, valid_out_q;
  logic [WIDTH-1:0] angle_out_q;
  logic [1:0]       quadrant_q;

  assign bus.ready     = ready_q;
  assign bus.angle_out = angle_out_q;
  assign bus.quadrant  = quadrant_q;
  assign bus.err       = err_q;
  assign bus.valid_out = valid_out_q;

  // Step counts: nb mantissa bits shifted in, then nz pure doublings.
  int k_c, nb_c, nz_c;
  always_comb begin
    k_c  = int'(ang_q[30:23]) - 150 + FB;
    nb_c = (k_c < 0) ? 24 + k_c : 24;
    if (nb_c < 0) nb_c = 0;
    nz_c = (k_c > 0) ? k_c : 0;
  end

  logic          b_d, mod_last;
  logic [RW-1:0] r2, r_d;
  always_comb begin
    b_d      = (nb_q != 5'd0) ? m_q[23] : 1'b0;
    r2       = {r_q[RW-2:0], b_d};
    r_d      = (r2 >= QM) ? r2 - QM : r2;
    mod_last = (nb_q == 5'd0) ? (nz_q == 8'd1) : (nb_q == 5'd1 && nz_q == 8'd0);
  end

  logic [RW:0]  rr, rs, off, res_d, mag;
  logic [1:0]   quad_d;
  logic [63:0]  num_d;
  always_comb begin
`ifdef ANGLE_REDUCER_ROUND_EN
    rr = ({1'b0, r_q} + (RW+1)'(1)) >> 1;
    if (rr == QF) rr = '0;
`else
    rr = {1'b0, r_q};
`endif
    rs = (ang_q[31] && rr != '0) ? QF - rr : rr;
    quad_d = 2'd0;
    off    = '0;
    if (rs < T45) begin
      quad_d = 2'd0;
    end else if (rs < T135) begin
      quad_d = 2'd1; off = O90;
    end else if (rs < T225) begin
      quad_d = 2'd2; off = O180;
    end else if (rs < T315) begin
      quad_d = 2'd3; off = O270;
    end else begin
      quad_d = 2'd0; off = QF;
    end
    res_d = rs - off;
    mag   = res_d[RW] ? -res_d : res_d;
    num_d = (64'(mag) << (WIDTH - 2)) + HALF;
  end

  // Restoring divide: remainder seeded with the dividend bits above the quotient window.
  logic [PW:0]   t_d;
  logic          q_bit;
  logic [PW-1:0] p_d;
  always_comb begin
    t_d   = {p_q, s_q[WIDTH-1]};
    q_bit = (t_d >= DV);
    p_d   = q_bit ? PW'(t_d - DV) : t_d[PW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ang_q       <= '0;
      m_q         <= '0;
      nb_q        <= '0;
      nz_q        <= '0;
      r_q         <= '0;
      p_q         <= '0;
      s_q         <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      quad_q      <= '0;
      neg_q       <= 1'b0;
      spec_err_q  <= 1'b0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      valid_out_q <= 1'b0;
      angle_out_q <= '0;
      quadrant_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ready_q && bus.valid_in) begin
            ang_q   <= bus.angle_in;
            ready_q <= 1'b0;
            state_q <= CLASSIFY;
          end else begin
            ready_q <= 1'b1;
          end
        end
        CLASSIFY: begin
          quad_q <= 2'd0;
          neg_q  <= 1'b0;
          if (ang_q[30:23] == 8'hFF || ang_q[30:23] == 8'h00) begin
            // Specials skip straight to the output stage with a zero quotient.
            spec_err_q <= (ang_q[30:23] == 8'hFF);
            quo_q      <= '0;
            cnt_q      <= 6'(WIDTH);
            state_q    <= DIV;
          end else begin
            spec_err_q <= 1'b0;
            r_q        <= '0;
            m_q        <= {1'b1, ang_q[22:0]};
            nb_q       <= 5'(nb_c);
            nz_q       <= 8'(nz_c);
            state_q    <= (nb_c + nz_c == 0) ? FOLD : MOD;
          end
        end
        MOD: begin
          r_q <= r_d;
          if (nb_q != 5'd0) begin
            m_q  <= m_q << 1;
            nb_q <= nb_q - 5'd1;
          end else begin
            nz_q <= nz_q - 8'd1;
          end
          if (mod_last) state_q <= FOLD;
        end
        FOLD: begin
          quad_q  <= quad_d;
          neg_q   <= res_d[RW];
          p_q     <= PW'(num_d >> WIDTH);
          s_q     <= num_d[WIDTH-1:0];
          quo_q   <= '0;
          cnt_q   <= '0;
          state_q <= DIV;
        end
        DIV: begin
          if (cnt_q == 6'(WIDTH)) begin
            angle_out_q <= neg_q ? -quo_q : quo_q;
            quadrant_q  <= quad_q;
            err_q       <= spec_err_q;
            valid_out_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            p_q   <= p_d;
            s_q   <= s_q << 1;
            quo_q <= {quo_q[WIDTH-2:0], q_bit};
            cnt_q <= cnt_q + 6'd1;
          end
        end
        DONE: begin
          if (bus.ready_out) begin
            valid_out_q <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_angle_reducer.sv
// Directed vectors with hand-computed results for angle_reducer (WIDTH=32, FRAC_BITS=16).
module tb_angle_reducer;
  localparam int WIDTH = 32;
`ifdef ANGLE_REDUCER_ROUND_EN
  localparam int          XL    = 1;
  localparam logic [31:0] EXP30 = 32'h2AAAAAAB;
`else
  localparam int          XL    = 0;
  localparam logic [31:0] EXP30 = 32'h2AAAAAAA;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  angle_reducer_if #(.WIDTH(WIDTH)) bus ();
  angle_reducer #(.WIDTH(WIDTH), .FRAC_BITS(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input logic [31:0] a);
    int w = 0;
    while (!bus.ready && w < 400) begin
      tick();
      w++;
    end
    check_eq({tag, "_ready"}, 32'(bus.ready), 32'd1);
    bus.angle_in = a;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.valid_out && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] e_out,
                     input logic [1:0] e_q, input logic e_err, input int e_lat);
    int lat;
    send(tag, a);
    wait_out(lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'(e_lat));
    check_eq({tag, "_out"}, bus.angle_out, e_out);
    check_eq({tag, "_quad"}, 32'(bus.quadrant), 32'(e_q));
    check_eq({tag, "_err"}, 32'(bus.err), 32'(e_err));
    tick();
    check_eq({tag, "_vld_clr"}, 32'(bus.valid_out), 32'd0);
    check_eq({tag, "_rdy_back"}, 32'(bus.ready), 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    bus.valid_in  = 1'b0;
    bus.angle_in  = '0;
    bus.ready_out = 1'b1;

    // Reset state
    tick();
    tick();
    check_eq("rst_ready", 32'(bus.ready), 32'd0);
    check_eq("rst_vld", 32'(bus.valid_out), 32'd0);
    check_eq("rst_out", bus.angle_out, 32'd0);
    check_eq("rst_quad", 32'(bus.quadrant), 32'd0);
    check_eq("rst_err", 32'(bus.err), 32'd0);
    rst = 1'b1;
    tick();
    check_eq("rst_ready_after", 32'(bus.ready), 32'd1);

    run("a30",   32'h41F00000, EXP30,               2'd0, 1'b0, 56 + XL);
    run("a100",  32'h42C80000, 32'd238609294,       2'd1, 1'b0, 58 + XL);
    run("m200",  32'hC3480000, 32'(-477218588),     2'd2, 1'b0, 59 + XL);
    run("a405",  32'h43CA8000, 32'(-1073741824),    2'd1, 1'b0, 60 + XL);
    run("a7200", 32'h45E10000, 32'd0,               2'd0, 1'b0, 64 + XL);
    run("nan",   32'h7FC00000, 32'd0,               2'd0, 1'b1, 2);
    run("minf",  32'hFF800000, 32'd0,               2'd0, 1'b1, 2);
    run("mzero", 32'h80000000, 32'd0,               2'd0, 1'b0, 2);

    // Backpressure: result held, ready low, stray valid_in ignored
    send("bp", 32'h41F00000);
    wait_out(lat);
    bus.ready_out = 1'b0;
    check_eq("bp_lat", 32'(lat), 32'(56 + XL));
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.angle_in = 32'h42C80000;
        bus.valid_in = 1'b1;
      end
      tick();
      bus.valid_in = 1'b0;
      check_eq("bp_vld", 32'(bus.valid_out), 32'd1);
      check_eq("bp_rdy", 32'(bus.ready), 32'd0);
      check_eq("bp_out", bus.angle_out, EXP30);
    end
    bus.ready_out = 1'b1;
    tick();
    check_eq("bp_release", 32'(bus.valid_out), 32'd0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.valid_out) seen++;
    end
    check_eq("bp_no_second", 32'(seen), 32'd0);
    check_eq("bp_out_kept", bus.angle_out, EXP30);

    // Reset mid-MOD on 1.0e30
    send("rstmid", 32'h7149F2CA);
    repeat (10) tick();
    rst = 1'b0;
    tick();
    check_eq("rm_vld", 32'(bus.valid_out), 32'd0);
    check_eq("rm_out", bus.angle_out, 32'd0);
    check_eq("rm_quad", 32'(bus.quadrant), 32'd0);
    check_eq("rm_err", 32'(bus.err), 32'd0);
    check_eq("rm_rdy_low", 32'(bus.ready), 32'd0);
    rst = 1'b1;
    tick();
    check_eq("rm_rdy_high", 32'(bus.ready), 32'd1);
    run("post_rst", 32'h41F00000, EXP30, 2'd0, 1'b0, 56 + XL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/angle_reducer.md
# angle_reducer

Parametrised successor to the integer-only angle normaliser. Accepts an IEEE-754 single-precision angle in degrees and performs exact bit-serial reduction modulo 360° in fixed point, keeping FRAC_BITS fractional bits. It folds the result into a quadrant index and a residual in [-45°, 45°), then scales the residual so that 45° = 2^(WIDTH-2). It sits between the processor interface and the CORDIC core and adds output backpressure and NaN/Inf flagging.

## Interface
- WIDTH, 32: signed output width; 45° maps to 2^(WIDTH-2); legal range 8..32.
- FRAC_BITS, 16: fractional bits kept during reduction; legal range 0..20. Modulus Q = 360·2^FRAC_BITS.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-low reset.
- valid_in  in  1  input strobe; sampled only while ready=1.
- angle_in  in  32  IEEE-754 float, degrees.
- ready  out  1  high only in IDLE.
- angle_out  out  WIDTH  signed scaled residual.
- quadrant  out  2  q; original angle ≡ residual + q·90° (mod 360°).
- err  out  1  input was NaN or ±Inf.
- valid_out  out  1  result valid; held until ready_out.
- ready_out  in  1  downstream accept.

## Operation
- States: IDLE, CLASSIFY, MOD, FOLD, DIV, DONE.
- IDLE: ready=1. valid_in=1 latches angle_in, goes to CLASSIFY, drops ready. valid_in in any other state is ignored.
- CLASSIFY:
  - exp=255: err=1, angle_out=0, quadrant=0, go to DONE.
  - exp=0 (zero or denormal): angle_out=0, quadrant=0, err=0, go to DONE.
  - Otherwise k = exp − 150 + FRAC_BITS and r = 0.
- MOD: one step per cycle, r = 2r + b, then subtract Q if r ≥ Q.
  - b iterates over the top 24+min(k,0) bits of {1,mantissa}, MSB first. These steps truncate the fraction below 2^-FRAC_BITS.
  - After that, max(k,0) further doubling steps with b=0.
  - N_mod = max(0, 24+min(k,0)) + max(k,0), at most 24+104+FRAC_BITS.
  - Invariant: r ∈ [0,Q) on every cycle.
- FOLD, one cycle:
  - If sign=1 and r≠0, r = Q − r.
  - With D = 2^FRAC_BITS: r<45D gives q0, residual r. r<135D gives q1, residual r−90D. r<225D gives q2, residual r−180D. r<315D gives q3, residual r−270D. Otherwise q0, residual r−360D.
  - −0.0 yields 0, q0.
- DIV: restoring unsigned divide over exactly WIDTH cycles: |residual|·2^(WIDTH-2) / (45·D). Reapply the sign. The quotient magnitude is at most 2^(WIDTH-2).
- DONE: valid_out=1, outputs stable. The cycle valid_out and ready_out are both high returns the block to IDLE with valid_out=0.

## Timing
- Reset values: ready=0 in the reset cycle and 1 from the next cycle (IDLE). angle_out=0, quadrant=0, err=0, valid_out=0.
- Latency from the valid_in acceptance edge to valid_out high: 1 + N_mod + 1 + WIDTH + 1 cycles. Special values (NaN, Inf, zero, denormal) take 2 cycles.
- With ready_out held high, a new input can be accepted 1 cycle after the valid_out handshake.
- Outputs change only on entry to DONE or on reset; they keep their values after the handshake until the next result.
- rst low in any state: the next edge enters IDLE and clears all outputs; any in-flight result is discarded.

## Configuration
- ANGLE_REDUCER_ROUND_EN defined:
  - MOD appends one guard bit. FOLD rounds r to nearest (ties away from zero) before the quadrant decision, with a post-round wrap at Q.
  - DIV adds a half-divisor before dividing, rounding magnitude to nearest.
  - Latency +1 cycle.
- Undefined: truncation toward zero in both MOD and DIV.

## Test plan
- Defaults, 30.0 (0x41F00000): quadrant=0, angle_out=0x2AAAAAAA (0x2AAAAAAB with ROUND_EN), err=0. Latency 56 cycles (57 with ROUND_EN).
- 100.0 → quadrant=1, angle_out=238609294. −200.0 → quadrant=2, angle_out=−477218588.
- 405.0 → quadrant=1, angle_out=−1073741824. 7200.0 → quadrant=0, angle_out=0.
- 0x7FC00000 (NaN) and 0xFF800000 (−Inf) → err=1, angle_out=0, quadrant=0, valid_out 2 cycles after acceptance.
- Hold ready_out=0 for 10 cycles after valid_out: outputs stable and ready=0. A valid_in pulse during this window is ignored, with no second result.
- Assert rst low mid-MOD on 1.0e30: next cycle valid_out=0, outputs 0, ready=1 one cycle after rst is released. Then 30.0 gives a correct result.
